// File: rtl/softmax_approx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | softmax_approx_pkg : Q-format constants shared by the log2/pow2 stages    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package softmax_approx_pkg;

    localparam int FRAC_W    = 10;
    localparam int LOG_INT_W = 6;
    localparam int LIN_W     = 32;

    localparam logic signed [LOG_INT_W-1:0] POW2_OVF_I         = 6'sd22;
    localparam logic signed [LOG_INT_W-1:0] POW2_UF_I          = -6'sd11;
    localparam logic        [LOG_INT_W-1:0] LOG2_ZERO_SENTINEL = 6'h20;

endpackage : softmax_approx_pkg
`default_nettype wire

// File: rtl/pow2_shift_sat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pow2_shift_sat : combinational bidirectional barrel shift with clamp      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pow2_shift_sat
    import softmax_approx_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int MANT_W = 11
) (
    input  logic                 i_int_neg,
    input  logic [LOG_INT_W-1:0] i_int,
    input  logic [MANT_W-1:0]    i_mant,
    input  logic                 i_ovf,
    input  logic                 i_uf,
    output logic [OUT_W-1:0]     o_value,
    output logic                 o_sat,
    output logic                 o_uf
);

    logic [OUT_W:0]          w_left;
    logic [LOG_INT_W-1:0]    w_rsh;
    logic [MANT_W-1:0]       w_right;

    // One spare bit above OUT_W catches any left-shift overflow the decode missed.
    assign w_left  = {{(OUT_W+1-MANT_W){1'b0}}, i_mant} << i_int[LOG_INT_W-2:0];
    assign w_rsh   = LOG_INT_W'(-i_int);
    assign w_right = i_mant >> w_rsh;

    always_comb begin
        o_value = '0;
        o_sat   = 1'b0;
        o_uf    = 1'b0;
        if (i_ovf) begin
            o_value = '1;
            o_sat   = 1'b1;
        end else if (i_uf) begin
            o_uf    = 1'b1;
        end else if (!i_int_neg) begin
            if (w_left[OUT_W]) begin
                o_value = '1;
                o_sat   = 1'b1;
            end else begin
                o_value = w_left[OUT_W-1:0];
            end
        end else begin
            o_value = {{(OUT_W-MANT_W){1'b0}}, w_right};
        end
    end

endmodule : pow2_shift_sat
`default_nettype wire

// File: rtl/stage_pow2_approx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_pow2_approx : 3-stage Mitchell antilog, signed Q6.10 -> Q22.10      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module stage_pow2_approx
    import softmax_approx_pkg::*;
#(
    parameter int FRAC_W = 10,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int BYP_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_log2,
    input  logic [BYP_W-1:0] i_byp,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_pow2,
    output logic [BYP_W-1:0] o_byp,
    output logic             o_sat,
    output logic             o_uf
);

    localparam int INT_W  = IN_W - FRAC_W;
    localparam int MANT_W = FRAC_W + 1;

    logic             r_s0_valid;
    logic [BYP_W-1:0] r_s0_byp;
    logic [IN_W-1:0]  r_s0_log2;

    logic               r_s1_valid;
    logic [BYP_W-1:0]   r_s1_byp;
    logic [INT_W-1:0]   r_s1_int;
    logic [MANT_W-1:0]  r_s1_mant;
    logic               r_s1_ovf;
    logic               r_s1_uf;

    logic               r_s2_valid;
    logic [BYP_W-1:0]   r_s2_byp;
    logic [OUT_W-1:0]   r_s2_pow2;
    logic               r_s2_sat;
    logic               r_s2_uf;

    logic signed [INT_W-1:0] w_int;
    logic                    w_ovf;
    logic                    w_uf;
    logic [OUT_W-1:0]        w_value;
    logic                    w_sat;
    logic                    w_sh_uf;

    // The -32 zero sentinel lands in the underflow range, so it never reaches negation.
    assign w_int = $signed(r_s0_log2[IN_W-1:FRAC_W]);
    assign w_ovf = (w_int >= POW2_OVF_I);
    assign w_uf  = (w_int <= POW2_UF_I);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_byp   <= '0;
            r_s0_log2  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_byp   <= '0;
            r_s1_int   <= '0;
            r_s1_mant  <= '0;
            r_s1_ovf   <= 1'b0;
            r_s1_uf    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_byp   <= '0;
            r_s2_pow2  <= '0;
            r_s2_sat   <= 1'b0;
            r_s2_uf    <= 1'b0;
        end else if (i_en) begin
            r_s0_valid <= i_valid;
            r_s0_byp   <= i_byp;
            r_s0_log2  <= i_log2;
            r_s1_valid <= r_s0_valid;
            r_s1_byp   <= r_s0_byp;
            r_s1_int   <= w_int;
            r_s1_mant  <= {1'b1, r_s0_log2[FRAC_W-1:0]};
            r_s1_ovf   <= w_ovf;
            r_s1_uf    <= w_uf;
            r_s2_valid <= r_s1_valid;
            r_s2_byp   <= r_s1_byp;
            r_s2_pow2  <= w_value;
            r_s2_sat   <= w_sat;
            r_s2_uf    <= w_sh_uf;
        end
    end

    pow2_shift_sat #(
        .OUT_W  (OUT_W),
        .MANT_W (MANT_W)
    ) u_shift_sat (
        .i_int_neg (r_s1_int[INT_W-1]),
        .i_int     (r_s1_int),
        .i_mant    (r_s1_mant),
        .i_ovf     (r_s1_ovf),
        .i_uf      (r_s1_uf),
        .o_value   (w_value),
        .o_sat     (w_sat),
        .o_uf      (w_sh_uf)
    );

    assign o_valid = r_s2_valid;
    assign o_pow2  = r_s2_pow2;
    assign o_byp   = r_s2_byp;
    assign o_sat   = r_s2_sat;
    assign o_uf    = r_s2_uf;

endmodule : stage_pow2_approx
`default_nettype wire

// File: tb/tb_stage_pow2_approx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stage_pow2_approx : directed + random checks against an antilog model  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_stage_pow2_approx;

    logic        clk;
    logic        rst_n;
    logic        i_en;
    logic        i_valid;
    logic [15:0] i_log2;
    logic [15:0] i_byp;
    logic        o_valid;
    logic [31:0] o_pow2;
    logic [15:0] o_byp;
    logic        o_sat;
    logic        o_uf;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        v;
        logic [31:0] p;
        logic [15:0] b;
        logic        s;
        logic        u;
    } ent_t;

    ent_t pend[$];
    ent_t cur;

    stage_pow2_approx dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (i_en),
        .i_valid (i_valid),
        .i_log2  (i_log2),
        .i_byp   (i_byp),
        .o_valid (o_valid),
        .o_pow2  (o_pow2),
        .o_byp   (o_byp),
        .o_sat   (o_sat),
        .o_uf    (o_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2^(I+F) ~= (1+F)*2^I with clamping, straight from the number format.
    function automatic ent_t model(input logic v, input logic [15:0] x, input logic [15:0] b);
        ent_t   e;
        int     ii;
        longint m;
        ii  = $signed(x[15:10]);
        m   = 64'd1024 + longint'(x[9:0]);
        e.v = v;
        e.b = b;
        e.s = 1'b0;
        e.u = 1'b0;
        if (ii >= 22) begin
            e.p = 32'hFFFF_FFFF;
            e.s = 1'b1;
        end else if (ii <= -11) begin
            e.p = 32'h0;
            e.u = 1'b1;
        end else if (ii >= 0) begin
            e.p = 32'(m * (longint'(1) << ii));
        end else begin
            e.p = 32'(m / (longint'(1) << (-ii)));
        end
        return e;
    endfunction

    function automatic ent_t zero_ent();
        ent_t e;
        e.v = 1'b0;
        e.p = '0;
        e.b = '0;
        e.s = 1'b0;
        e.u = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        pend.delete();
        pend.push_back(zero_ent());
        pend.push_back(zero_ent());
        cur = zero_ent();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(o_valid), 32'h0);
        chk({tag, ".pow2"},  o_pow2,        32'h0);
        chk({tag, ".byp"},   32'(o_byp),   32'h0);
        chk({tag, ".sat"},   32'(o_sat),   32'h0);
        chk({tag, ".uf"},    32'(o_uf),    32'h0);
    endtask

    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] b,
                        input logic en, input string tag);
        @(negedge clk);
        i_valid = v;
        i_log2  = x;
        i_byp   = b;
        i_en    = en;
        @(posedge clk);
        if (en) begin
            pend.push_back(model(v, x, b));
            cur = pend.pop_front();
        end
        #1;
        chk({tag, ".valid"}, 32'(o_valid), 32'(cur.v));
        if (cur.v) begin
            chk({tag, ".pow2"}, o_pow2,       cur.p);
            chk({tag, ".byp"},  32'(o_byp),   32'(cur.b));
            chk({tag, ".sat"},  32'(o_sat),   32'(cur.s));
            chk({tag, ".uf"},   32'(o_uf),    32'(cur.u));
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        i_en    = 1'b0;
        i_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_zero(tag);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic flush(input string tag);
        for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 16'h0, 1'b1, tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_en    = 1'b0;
        i_valid = 1'b0;
        i_log2  = '0;
        i_byp   = '0;
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic values
        step(1'b1, 16'h0000, 16'hABCD, 1'b1, "one");
        step(1'b1, 16'h0E00, 16'h0001, 1'b1, "three_half");
        step(1'b1, 16'hFC00, 16'h0002, 1'b1, "neg_one");
        flush("basic_flush");

        // Overflow and underflow edges
        step(1'b1, 16'h57FF, 16'h0010, 1'b1, "i21_max");
        step(1'b1, 16'h5800, 16'h0011, 1'b1, "i22_sat");
        step(1'b1, 16'h7FFF, 16'h0012, 1'b1, "max_sat");
        step(1'b1, 16'hD800, 16'h0020, 1'b1, "i_m10");
        step(1'b1, 16'hD400, 16'h0021, 1'b1, "i_m11_uf");
        step(1'b1, 16'h8000, 16'h0022, 1'b1, "sentinel");
        flush("edge_flush");

        // Stall and bubble
        step(1'b1, 16'h0000, 16'h0100, 1'b1, "stall_a");
        step(1'b1, 16'h0400, 16'h0101, 1'b1, "stall_b");
        step(1'b1, 16'h1234, 16'h0BAD, 1'b0, "stall_hold1");
        step(1'b0, 16'h4321, 16'h0BAD, 1'b0, "stall_hold2");
        step(1'b1, 16'h0800, 16'h0102, 1'b1, "stall_c");
        step(1'b0, 16'h0C00, 16'h0103, 1'b1, "bubble");
        step(1'b1, 16'h0C00, 16'h0104, 1'b1, "after_bubble");
        flush("stall_flush");

        // Async reset with samples in flight
        step(1'b1, 16'h0400, 16'h0201, 1'b1, "inflight_a");
        step(1'b1, 16'h0800, 16'h0202, 1'b1, "inflight_b");
        step(1'b1, 16'h0C00, 16'h0203, 1'b1, "inflight_c");
        async_reset("midreset");
        step(1'b1, 16'h1000, 16'h0301, 1'b1, "post_rst1");
        step(1'b1, 16'h1400, 16'h0302, 1'b1, "post_rst2");
        step(1'b1, 16'h1800, 16'h0303, 1'b1, "post_rst3");
        flush("post_rst_flush");

        // Random traffic, biased toward the interesting integer range
        for (int n = 0; n < 400; n++) begin
            logic [15:0] x;
            logic [5:0]  iv;
            x = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                iv = 6'($signed(7'($urandom_range(0, 35)) - 7'sd12));
                x[15:10] = iv;
            end
            step(1'($urandom_range(0, 3) != 0), x, 16'($urandom),
                 1'($urandom_range(0, 3) != 0), "rand");
            if (n == 200) async_reset("rand_reset");
        end
        flush("final_flush");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_stage_pow2_approx
`default_nettype wire
